// File: rtl/operand_loader.sv
// Operand loader: captures operand A (with mode) then operand B and presents the pair with a valid/ready handshake.
// Optional FP16_CANON_EN macro canonicalises float-mode operands (zero/subnormal flush, NaN quieting) at capture.
module operand_loader #(
    parameter logic [31:0] TIMEOUT = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic        in_load,
    input  logic [1:0]  in_mode,
    input  logic        in_clear,
    input  logic        out_ready,
    output logic [15:0] out_num1,
    output logic [15:0] out_num2,
    output logic [1:0]  out_mode,
    output logic        out_valid,
    output logic        busy,
    output logic        timeout,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, WAIT_B, VALID} state_t;

    state_t      state, state_nx;
    logic [15:0] num1_nx, num2_nx;
    logic [1:0]  mode_nx;
    logic [31:0] cnt, cnt_nx;
    logic        timeout_nx, overrun_nx;
    logic [15:0] cap_a, cap_b;

`ifdef FP16_CANON_EN
    function automatic logic [15:0] canon(input logic [15:0] d, input logic is_float);
        if (is_float && d[14:10] == 5'd0)
            return {d[15], 15'b0};
        else if (is_float && d[14:10] == 5'h1F && d[9:0] != 10'd0)
            return 16'h7E00;
        else
            return d;
    endfunction

    // A uses the mode arriving with it; B uses the mode already latched with A.
    assign cap_a = canon(in_data, in_mode[1]);
    assign cap_b = canon(in_data, out_mode[1]);
`else
    assign cap_a = in_data;
    assign cap_b = in_data;
`endif

    assign out_valid = (state == VALID);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx   = state;
        num1_nx    = out_num1;
        num2_nx    = out_num2;
        mode_nx    = out_mode;
        cnt_nx     = cnt;
        timeout_nx = 1'b0;
        overrun_nx = overrun;
        if (in_clear) begin
            state_nx   = IDLE;
            cnt_nx     = '0;
            overrun_nx = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_load) begin
                        num1_nx  = cap_a;
                        mode_nx  = in_mode;
                        cnt_nx   = '0;
                        state_nx = WAIT_B;
                    end
                end
                WAIT_B: begin
                    // A load on the expiry cycle takes precedence over the timeout.
                    if (in_load) begin
                        num2_nx  = cap_b;
                        state_nx = VALID;
                    end else if (TIMEOUT != 32'd0 && cnt == TIMEOUT - 32'd1) begin
                        state_nx   = IDLE;
                        timeout_nx = 1'b1;
                    end else if (cnt != '1) begin
                        cnt_nx = cnt + 32'd1;
                    end
                end
                VALID: begin
                    if (out_ready) begin
                        if (in_load) begin
                            num1_nx  = cap_a;
                            mode_nx  = in_mode;
                            cnt_nx   = '0;
                            state_nx = WAIT_B;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else if (in_load) begin
                        overrun_nx = 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            out_num1 <= '0;
            out_num2 <= '0;
            out_mode <= '0;
            cnt      <= '0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nx;
            out_num1 <= num1_nx;
            out_num2 <= num2_nx;
            out_mode <= mode_nx;
            cnt      <= cnt_nx;
            timeout  <= timeout_nx;
            overrun  <= overrun_nx;
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: per-cycle comparison against a behavioural model plus literal spot checks.
module tb_operand_loader;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_load = 1'b0;
    logic [1:0]  in_mode = '0;
    logic        in_clear = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] out_num1, out_num2;
    logic [1:0]  out_mode;
    logic        out_valid, busy, timeout, overrun;

    int unsigned checks = 0;
    int unsigned errors = 0;

    operand_loader #(.TIMEOUT(32'd8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_load(in_load),
        .in_mode(in_mode), .in_clear(in_clear), .out_ready(out_ready),
        .out_num1(out_num1), .out_num2(out_num2), .out_mode(out_mode),
        .out_valid(out_valid), .busy(busy), .timeout(timeout), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_capture(input logic [15:0] d, input logic is_float);
`ifdef FP16_CANON_EN
        if (is_float && d[14:10] == 5'd0) return {d[15], 15'b0};
        if (is_float && d[14:10] == 5'h1F && d[9:0] != 10'd0) return 16'h7E00;
`endif
        if (is_float) return d;
        return d;
    endfunction

    // Model: phase 0 = nothing held, 1 = holding A awaiting B, 2 = pair offered.
    int unsigned phase = 0;
    int unsigned waited = 0;
    logic [15:0] e1 = '0, e2 = '0;
    logic [1:0]  em = '0;
    logic        eto = 1'b0, eov = 1'b0;
    bit          started = 1'b0;

    always @(posedge clk) begin
        eto = 1'b0;
        if (!rst_n) begin
            started = 1'b1;
            phase = 0; waited = 0; e1 = '0; e2 = '0; em = '0; eov = 1'b0;
        end else if (in_clear) begin
            phase = 0; waited = 0; eov = 1'b0;
        end else if (phase == 0) begin
            if (in_load) begin
                e1 = model_capture(in_data, in_mode[1]); em = in_mode; waited = 0; phase = 1;
            end
        end else if (phase == 1) begin
            if (in_load) begin
                e2 = model_capture(in_data, em[1]); phase = 2;
            end else begin
                waited++;
                if (TO != 0 && waited == TO) begin
                    phase = 0; eto = 1'b1;
                end
            end
        end else begin
            if (out_ready) begin
                if (in_load) begin
                    e1 = model_capture(in_data, in_mode[1]); em = in_mode; waited = 0; phase = 1;
                end else begin
                    phase = 0;
                end
            end else if (in_load) begin
                eov = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("num1", 32'(out_num1), 32'(e1));
            check("num2", 32'(out_num2), 32'(e2));
            check("mode", 32'(out_mode), 32'(em));
            check("valid", 32'(out_valid), 32'(phase == 2));
            check("busy", 32'(busy), 32'(phase != 0));
            check("timeout", 32'(timeout), 32'(eto));
            check("overrun", 32'(overrun), 32'(eov));
        end
    end

    task automatic step(input logic ld, input logic [15:0] d, input logic [1:0] m,
                        input logic rdy, input logic clr);
        in_load = ld; in_data = d; in_mode = m; out_ready = rdy; in_clear = clr;
        @(posedge clk);
        #1;
        in_load = 1'b0; in_clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        step(0, 16'h0, 2'b00, 0, 0);
        step(0, 16'h0, 2'b00, 0, 0);
        check("rst_num1", 32'(out_num1), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Basic pair with handshake
        step(1, 16'd27, 2'b00, 1, 0);
        check("basic_busyA", 32'(busy), 32'h1);
        step(1, 16'd42, 2'b00, 1, 0);
        check("basic_valid", 32'(out_valid), 32'h1);
        check("basic_num1", 32'(out_num1), 32'd27);
        check("basic_num2", 32'(out_num2), 32'd42);
        step(0, 16'h0, 2'b00, 1, 0);
        check("basic_idle", 32'(busy), 32'h0);

        // Timeout after 8 cycles in WAIT_B
        step(1, 16'hAA8E, 2'b01, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 16'h0, 2'b00, 0, 0);
        check("to_early", 32'(timeout), 32'h0);
        step(0, 16'h0, 2'b00, 0, 0);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_busy", 32'(busy), 32'h0);
        check("to_num1", 32'(out_num1), 32'hAA8E);
        step(0, 16'h0, 2'b00, 0, 0);
        check("to_once", 32'(timeout), 32'h0);

        // Load on the expiry cycle wins over timeout
        step(1, 16'h0101, 2'b01, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 16'h0, 2'b00, 0, 0);
        step(1, 16'h0202, 2'b00, 0, 0);
        check("exp_valid", 32'(out_valid), 32'h1);
        check("exp_noto", 32'(timeout), 32'h0);
        step(0, 16'h0, 2'b00, 1, 0);

        // Overrun in VALID, then clear
        step(1, 16'd561, 2'b00, 0, 0);
        step(1, 16'd158, 2'b00, 0, 0);
        step(1, 16'd999, 2'b01, 0, 0);
        check("ov_flag", 32'(overrun), 32'h1);
        check("ov_num1", 32'(out_num1), 32'd561);
        check("ov_num2", 32'(out_num2), 32'd158);
        step(0, 16'h0, 2'b00, 0, 0);
        step(0, 16'h0, 2'b00, 0, 1);
        check("clr_ov", 32'(overrun), 32'h0);
        check("clr_busy", 32'(busy), 32'h0);
        check("clr_num1", 32'(out_num1), 32'd561);

        // Same-edge handshake and new A
        step(1, 16'd1, 2'b00, 0, 0);
        step(1, 16'd2, 2'b00, 0, 0);
        step(1, 16'hFDBA, 2'b01, 1, 0);
        check("b2b_num1", 32'(out_num1), 32'hFDBA);
        check("b2b_valid", 32'(out_valid), 32'h0);
        check("b2b_busy", 32'(busy), 32'h1);
        step(1, 16'd3, 2'b00, 0, 0);
        step(0, 16'h0, 2'b00, 1, 0);

        // Float-mode capture
        step(1, 16'h8123, 2'b10, 0, 0);
        step(1, 16'h7C01, 2'b00, 0, 0);
`ifdef FP16_CANON_EN
        check("fp_num1", 32'(out_num1), 32'h8000);
        check("fp_num2", 32'(out_num2), 32'h7E00);
`else
        check("fp_num1", 32'(out_num1), 32'h8123);
        check("fp_num2", 32'(out_num2), 32'h7C01);
`endif
        // Clear beats a simultaneous handshake + load
        step(1, 16'h7777, 2'b00, 1, 1);
        check("clrpri_busy", 32'(busy), 32'h0);
        check("clrpri_num1", 32'(out_num1), 32'(model_capture(16'h8123, 1'b1)));

        // Reset during WAIT_B
        step(1, 16'h1234, 2'b11, 0, 0);
        rst_n = 1'b0;
        step(1, 16'h4321, 2'b00, 1, 1);
        check("mrst_num1", 32'(out_num1), 32'h0);
        check("mrst_mode", 32'(out_mode), 32'h0);
        check("mrst_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
        step(1, 16'h5555, 2'b01, 0, 0);
        check("mrst_newA", 32'(out_num1), 32'h5555);
        check("mrst_busyA", 32'(busy), 32'h1);
        step(1, 16'h6666, 2'b00, 1, 0);
        step(0, 16'h0, 2'b00, 1, 0);
        step(0, 16'h0, 2'b00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter TIMEOUT, default 32'd100_000_000, maximum cycles spent in WAIT_B before abandoning operand A; 0 disables the timeout.
REQ-002 clk  in  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 in_data  in  16  operand word (8.8 fixed or FP16, per mode).
REQ-005 in_load  in  1  one-cycle strobe; captures in_data as next operand.
REQ-006 in_mode  in  2  bit1: 1=float, 0=fixed; bit0: 1=multiply, 0=add; sampled with operand A only.
REQ-007 in_clear  in  1  abort; returns to IDLE and clears sticky flags.
REQ-008 out_ready  in  1  downstream accepts the operand pair.
REQ-009 out_num1  out  16  registered operand A, to the adder/multiplier core.
REQ-010 out_num2  out  16  registered operand B, to the adder/multiplier core.
REQ-011 out_mode  out  2  registered mode captured with A.
REQ-012 out_valid  out  1  operand pair complete and stable.
REQ-013 busy  out  1  high in WAIT_B or VALID.
REQ-014 timeout  out  1  one-cycle pulse when WAIT_B expires.
REQ-015 overrun  out  1  sticky; in_load received in VALID without handshake.

Function
REQ-016 FSM states IDLE, WAIT_B, VALID; out_valid=1 only in VALID, busy=1 in WAIT_B or VALID.
REQ-017 IDLE + in_load: out_num1<=in_data, out_mode<=in_mode, wait counter<=0, -> WAIT_B next cycle.
REQ-018 WAIT_B + in_load: out_num2<=in_data, -> VALID next cycle (out_valid high exactly one cycle after B strobe).
REQ-019 WAIT_B, no load: counter increments each cycle; when counter == TIMEOUT-1 (TIMEOUT!=0) -> IDLE, timeout pulses high for that transition cycle only; out_num1/out_num2 retain values.
REQ-020 WAIT_B: in_load on the expiry cycle wins; B captured, no timeout pulse.
REQ-021 VALID: out_num1, out_num2, out_mode held constant until handshake (out_valid & out_ready).
REQ-022 VALID + out_ready, no load: -> IDLE.
REQ-023 VALID + out_ready + in_load: handshake completes and in_data/in_mode captured as new A, -> WAIT_B (back-to-back pairs, no idle cycle).
REQ-024 VALID + in_load, no out_ready: load ignored, operands unchanged, overrun<=1 (sticky).
REQ-025 in_clear in any state: -> IDLE next cycle, overrun<=0, counter<=0; in_clear has priority over in_load and out_ready; operand registers retain values.
REQ-026 Counter width 32 bits; never wraps (stops at expiry).

Reset
REQ-027 rst_n=0 at a rising edge: state<=IDLE, out_num1<=0, out_num2<=0, out_mode<=0, out_valid<=0, busy<=0, timeout<=0, overrun<=0, counter<=0.
REQ-028 Reset mid-operation (WAIT_B or VALID) discards the partial/pending pair; first cycle after release is IDLE, accepts in_load.
REQ-029 rst_n has priority over in_clear and all other inputs.

Configuration
REQ-030 Macro FP16_CANON_EN: when defined and in_mode/out_mode bit1=1 (float), each operand is canonicalised at capture: exponent 0 -> {sign,15'b0}; exponent 31 with nonzero fraction -> 16'h7E00; all others unchanged.
REQ-031 Without FP16_CANON_EN, operands are captured bit-exact in every mode; fixed-mode operands are always bit-exact.

Verification
REQ-032 Reset, load 16'd27 then 16'd42, mode 2'b00, out_ready=1 -> out_valid one cycle after second strobe, out_num1=27, out_num2=42, out_mode=00, then IDLE.
REQ-033 TIMEOUT=8, load A=16'hAA8E, no B -> timeout pulse 8 cycles after WAIT_B entry, state IDLE, busy=0, out_num1 still 16'hAA8E.
REQ-034 Pair 561/158 in VALID, out_ready=0, pulse in_load -> overrun=1, operands unchanged; then in_clear -> IDLE, overrun=0.
REQ-035 VALID with out_ready=1 and in_load=1 with in_data=16'hFDBA -> same-edge handshake, out_num1=16'hFDBA, state WAIT_B, out_valid=0.
REQ-036 FP16_CANON_EN defined, mode 2'b10, load 16'h8123 then 16'h7C01 -> out_num1=16'h8000, out_num2=16'h7E00; undefined -> 16'h8123, 16'h7C01.
REQ-037 Assert rst_n=0 during WAIT_B -> next cycle all outputs zero, state IDLE; following in_load captures new A normally.
